power_iteration_ctrl: RTL and testbench

Sequential power-iteration engine that sits directly upstream of `convergence_check` in the fetal-ECG eigenvector path. It repeatedly multiplies a covariance matrix by the current estimate vector using one shared MAC and block-normalises the result. It then presents `vector`, `next_vector` and `count_k` to the convergence checker. It samples the checker's `converged` output and either starts the next iteration or finishes, with a timeout flag when `MAX_ITER` is reached.

---
 rtl/fecg_pkg.sv | 41 ++++
 rtl/mac_unit.sv | 34 +++
 rtl/power_iteration_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_power_iteration_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fecg_pkg.sv
// Shared definitions for the fetal-ECG eigenvector path.
//   pi_state_t : state encoding of power_iteration_ctrl
//   ACC_W      : MAC accumulator width
//   DATA_W     : matrix / vector element width
//   sat32      : clamp a 64-bit signed value into the signed 32-bit range
//   msb_index  : index of the highest set bit of a 32-bit word (0 for zero)
package fecg_pkg;

   localparam int ACC_W  = 64;
   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MAC   = 3'd1,
      ST_NORM  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } pi_state_t;

   function automatic logic signed [DATA_W-1:0] sat32(input logic signed [ACC_W-1:0] x);
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      hi = ACC_W'(64'sh0000_0000_7fff_ffff);
      lo = ACC_W'(-64'sh0000_0000_8000_0000);
      if (x > hi)
         sat32 = 32'sh7fff_ffff;
      else if (x < lo)
         sat32 = 32'sh8000_0000;
      else
         sat32 = x[DATA_W-1:0];
   endfunction

   function automatic int msb_index(input logic [DATA_W-1:0] x);
      msb_index = 0;
      for (int k = 0; k < DATA_W; k++) begin
         if (x[k])
            msb_index = k;
      end
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate unit with a 64-bit signed accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : start a new sum from the current product (used with en)
//   en       : update the accumulator this cycle
//   a, b     : signed DATA_W operands
//   acc      : registered accumulator
//   sum      : value acc takes on the next edge when en=1 (includes a*b now)
module mac_unit
   import fecg_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc,
   output logic signed [ACC_W-1:0]  sum
);

   logic signed [ACC_W-1:0] prod;

   // Operands sign-extended before multiplying so the full 64-bit product is kept.
   assign prod = ACC_W'(a) * ACC_W'(b);
   assign sum  = (clr ? '0 : acc) + prod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (en)
         acc <= sum;
   end

endmodule

// File: rtl/power_iteration_ctrl.sv
// Power-iteration engine: computes A*vector with one shared MAC, block
// normalises the result into next_vector and hands both to convergence_check.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : run request, accepted only in IDLE
//   matrix       : SIZE_N x SIZE_N covariance matrix, held stable while busy
//   init_vector  : starting estimate, sampled on accepted start
//   converged    : checker verdict, sampled on the last CHECK cycle
//   vector       : current estimate
//   next_vector  : normalised A*vector
//   count_k      : completed iterations
//   busy, done   : run in progress / one-cycle end-of-run pulse
//   timeout      : run ended on MAX_ITER
//   zero_err     : A*vector was all zeros
//   state_dbg    : current FSM state
//
// Handshake: start is a single-cycle request with no acknowledge; it is taken
// only while state is IDLE, and busy rising on the next cycle confirms it.
module power_iteration_ctrl
   import fecg_pkg::*;
#(
   parameter int SIZE_N    = 8,
   parameter int MAX_ITER  = 100,
   parameter int FRAC_BITS = 16,
   parameter int CHECK_LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] matrix      [SIZE_N][SIZE_N],
   input  logic signed [DATA_W-1:0] init_vector [SIZE_N],
   input  logic                     converged,
   output logic signed [DATA_W-1:0] vector      [SIZE_N],
   output logic signed [DATA_W-1:0] next_vector [SIZE_N],
   output logic [31:0]              count_k,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic                     zero_err,
   output pi_state_t                state_dbg
);

   localparam int IW = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
   localparam int CW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(SIZE_N - 1);
   localparam logic [CW-1:0] LAST_CHK = CW'(CHECK_LAT - 1);

   pi_state_t                state;
   logic [IW-1:0]            i;
   logic [IW-1:0]            j;
   logic [CW-1:0]            chk_cnt;
   logic signed [DATA_W-1:0] temp [SIZE_N];
   logic [DATA_W-1:0]        maxabs;

   logic                     mac_en;
   logic                     mac_clr;
   logic signed [ACC_W-1:0]  mac_acc;
   logic signed [ACC_W-1:0]  mac_sum;
   logic signed [DATA_W-1:0] row_val;
   logic [DATA_W-1:0]        row_abs;
   logic [5:0]               shift_amt;

   assign state_dbg = state;
   assign mac_en    = (state == ST_MAC);
   assign mac_clr   = (j == '0);

   mac_unit u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (matrix[i][j]),
      .b   (vector[j]),
      .acc (mac_acc),
      .sum (mac_sum)
   );

   // Row result and its magnitude; |-2^31| does not fit, so it saturates.
   always_comb begin
      row_val = sat32(mac_sum >>> FRAC_BITS);
      row_abs = '0;
      if (row_val == 32'sh8000_0000)
         row_abs = 32'h7fff_ffff;
      else if (row_val < 0)
         row_abs = DATA_W'(-row_val);
      else
         row_abs = DATA_W'(row_val);
   end

   // Right-shift that brings the largest magnitude below 2^FRAC_BITS; never negative.
   always_comb begin
      shift_amt = '0;
      if (msb_index(maxabs) >= FRAC_BITS)
         shift_amt = 6'(msb_index(maxabs) - FRAC_BITS + 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         i        <= '0;
         j        <= '0;
         chk_cnt  <= '0;
         maxabs   <= '0;
         count_k  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         timeout  <= 1'b0;
         zero_err <= 1'b0;
         for (int k = 0; k < SIZE_N; k++) begin
            vector[k]      <= '0;
            next_vector[k] <= '0;
            temp[k]        <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  for (int k = 0; k < SIZE_N; k++)
                     vector[k] <= init_vector[k];
                  count_k  <= '0;
                  i        <= '0;
                  j        <= '0;
                  maxabs   <= '0;
                  timeout  <= 1'b0;
                  zero_err <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_MAC;
               end
            end

            ST_MAC: begin
               if (j == LAST_IDX) begin
                  temp[i] <= row_val;
                  if (row_abs > maxabs)
                     maxabs <= row_abs;
                  j <= '0;
                  if (i == LAST_IDX) begin
                     i     <= '0;
                     state <= ST_NORM;
                  end else begin
                     i <= i + 1'b1;
                  end
               end else begin
                  j <= j + 1'b1;
               end
            end

            ST_NORM: begin
               if (maxabs == '0) begin
                  zero_err <= 1'b1;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  for (int k = 0; k < SIZE_N; k++)
                     next_vector[k] <= temp[k] >>> shift_amt;
                  count_k <= count_k + 32'd1;
                  maxabs  <= '0;
                  chk_cnt <= '0;
                  state   <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (chk_cnt == LAST_CHK) begin
                  // converged wins over the iteration limit
                  if (converged) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else if (count_k == 32'(MAX_ITER)) begin
                     timeout <= 1'b1;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= ST_DONE;
                  end else begin
                     for (int k = 0; k < SIZE_N; k++)
                        vector[k] <= next_vector[k];
                     i     <= '0;
                     j     <= '0;
                     state <= ST_MAC;
                  end
               end else begin
                  chk_cnt <= chk_cnt + 1'b1;
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_power_iteration_ctrl.sv
// Directed bench for power_iteration_ctrl with SIZE_N=2, MAX_ITER=3,
// FRAC_BITS=16, CHECK_LAT=2 (one iteration = 4 + 1 + 2 = 7 cycles).
module tb_power_iteration_ctrl;
   import fecg_pkg::*;

   localparam int N  = 2;
   localparam int MI = 3;
   localparam int FB = 16;
   localparam int CL = 2;

   logic                     clk;
   logic                     rst;
   logic                     start;
   logic signed [DATA_W-1:0] matrix      [N][N];
   logic signed [DATA_W-1:0] init_vector [N];
   logic                     converged;
   logic signed [DATA_W-1:0] vector      [N];
   logic signed [DATA_W-1:0] next_vector [N];
   logic [31:0]              count_k;
   logic                     busy;
   logic                     done;
   logic                     timeout;
   logic                     zero_err;
   pi_state_t                state_dbg;

   int checks;
   int errors;
   int done_cnt;

   power_iteration_ctrl #(
      .SIZE_N(N), .MAX_ITER(MI), .FRAC_BITS(FB), .CHECK_LAT(CL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .matrix      (matrix),
      .init_vector (init_vector),
      .converged   (converged),
      .vector      (vector),
      .next_vector (next_vector),
      .count_k     (count_k),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .zero_err    (zero_err),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done)
         done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_diag(input int a0, input int a1);
      matrix[0][0] = a0;
      matrix[0][1] = 0;
      matrix[1][0] = 0;
      matrix[1][1] = a1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts cycles from busy rising to done; budget expiry counts as a failure.
   task automatic wait_done(input string tag, output int cycles);
      cycles = 0;
      while (!done && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      check({tag, "_done_seen"}, 64'(done), 64'd1);
   endtask

   int cyc;
   int dc0;
   int guard;

   initial begin
      checks    = 0;
      errors    = 0;
      done_cnt  = 0;
      start     = 1'b0;
      converged = 1'b0;
      set_diag(65536, 65536);
      init_vector[0] = 65536;
      init_vector[1] = 65536;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy",  64'(busy), 64'd0);
      check("rst_count", 64'(count_k), 64'd0);
      check("rst_vec0",  64'(vector[0]), 64'd0);
      check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      rst = 1'b0;

      // identity, one iteration, converged held high
      converged = 1'b1;
      pulse_start();
      check("id_busy", 64'(busy), 64'd1);
      wait_done("id", cyc);
      check("id_cycles", 64'(cyc), 64'd7);
      check("id_busy_low", 64'(busy), 64'd0);
      check("id_nv0", 64'(next_vector[0]), 64'd32768);
      check("id_nv1", 64'(next_vector[1]), 64'd32768);
      check("id_count", 64'(count_k), 64'd1);
      check("id_timeout", 64'(timeout), 64'd0);
      @(negedge clk);
      check("id_done_pulse", 64'(done), 64'd0);

      // dominant-eigen scaling
      set_diag(131072, 65536);
      init_vector[0] = 32768;
      init_vector[1] = 32768;
      pulse_start();
      wait_done("dom", cyc);
      check("dom_nv0", 64'(next_vector[0]), 64'd32768);
      check("dom_nv1", 64'(next_vector[1]), 64'd16384);
      check("dom_vec0", 64'(vector[0]), 64'd32768);
      check("dom_count", 64'(count_k), 64'd1);

      // timeout: identity, never converges; second iteration uses s=0
      converged = 1'b0;
      set_diag(65536, 65536);
      init_vector[0] = 65536;
      init_vector[1] = 65536;
      pulse_start();
      wait_done("to", cyc);
      check("to_cycles", 64'(cyc), 64'd21);
      check("to_count", 64'(count_k), 64'd3);
      check("to_timeout", 64'(timeout), 64'd1);
      check("to_nv0", 64'(next_vector[0]), 64'd32768);
      check("to_vec1", 64'(vector[1]), 64'd32768);

      // zero matrix: done right after NORM
      set_diag(0, 0);
      pulse_start();
      wait_done("zero", cyc);
      check("zero_cycles", 64'(cyc), 64'd5);
      check("zero_err", 64'(zero_err), 64'd1);
      check("zero_count", 64'(count_k), 64'd0);
      check("zero_timeout", 64'(timeout), 64'd0);

      // reset during MAC
      set_diag(65536, 65536);
      converged = 1'b1;
      pulse_start();
      repeat (2) @(negedge clk);
      check("mid_state", 64'(state_dbg), 64'(ST_MAC));
      dc0 = done_cnt;
      rst = 1'b1;
      #1;
      check("mid_busy", 64'(busy), 64'd0);
      check("mid_vec0", 64'(vector[0]), 64'd0);
      check("mid_nv0", 64'(next_vector[0]), 64'd0);
      check("mid_zero_err", 64'(zero_err), 64'd0);
      check("mid_state_idle", 64'(state_dbg), 64'(ST_IDLE));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_no_done", 64'(done_cnt), 64'(dc0));
      pulse_start();
      wait_done("mid_rerun", cyc);
      check("mid_rerun_cycles", 64'(cyc), 64'd7);
      check("mid_rerun_nv1", 64'(next_vector[1]), 64'd32768);

      // start during CHECK ignored; converged together with count_k=MAX_ITER
      converged = 1'b0;
      repeat (2) @(negedge clk);
      dc0 = done_cnt;
      pulse_start();
      cyc = 0;
      guard = 0;
      while (!done && guard < 200) begin
         start     = (state_dbg == ST_CHECK) && (count_k == 32'd1);
         converged = (state_dbg == ST_CHECK) && (count_k == 32'd3);
         @(negedge clk);
         cyc++;
         guard++;
      end
      start = 1'b0;
      check("pri_done_seen", 64'(done), 64'd1);
      check("pri_cycles", 64'(cyc), 64'd21);
      check("pri_count", 64'(count_k), 64'd3);
      check("pri_timeout", 64'(timeout), 64'd0);
      // start in the DONE cycle must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      converged = 1'b0;
      check("pri_done_start_busy", 64'(busy), 64'd0);
      check("pri_done_start_state", 64'(state_dbg), 64'(ST_IDLE));
      repeat (3) @(negedge clk);
      check("pri_one_done", 64'(done_cnt - dc0), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
